// File: rtl/bp_ctrl_pkg.sv
// rtl/bp_ctrl_pkg.sv - shared defaults and sizing helper for the predictor update scheduler
package bp_ctrl_pkg;

    localparam int BP_FIFO_DEPTH_DEF = 4;
    localparam int BP_MAX_DEFER_DEF  = 3;

    // Bits needed to encode the values 0..value-1, never fewer than one.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_rr_arbiter.sv
// rtl/bp_rr_arbiter.sv - round-robin grant among resolution requesters
module bp_rr_arbiter
    import bp_ctrl_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               enable,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Rotating-priority search beginning at the pointer, first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (enable && !found && valid[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
            cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    // Pointer moves just past the winner only when the grant was taken.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// rtl/bp_update_scheduler.sv - serialises branch resolutions onto the predictor update port
module bp_update_scheduler
    import bp_ctrl_pkg::*;
#(
    parameter int  NUM_REQ    = 2,
    parameter int  FIFO_DEPTH = BP_FIFO_DEPTH_DEF,
    parameter int  MAX_DEFER  = BP_MAX_DEFER_DEF,
    localparam int IDX_W      = clog2(NUM_REQ),
    localparam int PTR_W      = clog2(FIFO_DEPTH),
    localparam int CNT_W      = clog2(FIFO_DEPTH + 1),
    localparam int DEF_W      = clog2(MAX_DEFER + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_taken,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic               predict_request,
    output logic               update_enable,
    output logic               actual_taken,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               defer_hit
);

    logic [FIFO_DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEF_W-1:0]      defer_q, defer_d;
    logic                  update_enable_q, update_enable_d;
    logic                  actual_taken_q, actual_taken_d;
    logic                  defer_hit_q, defer_hit_d;

    logic                  full;
    logic                  empty;
    logic                  transfer;
    logic                  issue;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;

    // A full FIFO refuses everyone, even when the head leaves this same cycle.
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign transfer = |grant;
    // Hold off while fetch predicts so the GHR-hashed index stays stable, but never forever.
    assign issue    = !empty && (!predict_request || (defer_q == DEF_W'(MAX_DEFER)));

    bp_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid),
        .enable    (!rst && !full),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready     = grant;
    assign update_enable = update_enable_q;
    assign actual_taken  = actual_taken_q;
    assign defer_hit     = defer_hit_q;
    assign fifo_count    = count_q;

    // Next-state for FIFO, defer counter and the registered update port.
    always_comb begin
        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        update_enable_d = issue;
        actual_taken_d  = issue ? mem_q[rd_ptr_q] : actual_taken_q;
        defer_hit_d     = issue && predict_request;
        // Not issuing with entries pending only happens while predict_request holds us off.
        defer_d         = (empty || issue) ? '0 : defer_q + 1'b1;

        if (transfer) begin
            mem_d[wr_ptr_q] = req_taken[grant_idx];
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({transfer, issue})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops any pending updates without issuing them.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            defer_q         <= '0;
            update_enable_q <= 1'b0;
            actual_taken_q  <= 1'b0;
            defer_hit_q     <= 1'b0;
        end else begin
            mem_q           <= mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            defer_q         <= defer_d;
            update_enable_q <= update_enable_d;
            actual_taken_q  <= actual_taken_d;
            defer_hit_q     <= defer_hit_d;
        end
    end

endmodule
